// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'hBFC00000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h00000013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_DROP  = 3'd3,
        S_HOLD  = 3'd4
    } fetch_state_e;

    // Word-align an address; instruction fetches never use the low two bits.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise a bubble is inserted.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            hold_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic            valid_q;

    // A flush or bubble only kills the instruction; pc_o keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (!hold_i) begin
            if (load_i) begin
                instr_q    <= instr_i;
                pc_q       <= pc_i;
                pc_plus4_q <= pc_i + 32'd4;
                valid_q    <= 1'b1;
            end else begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: pc, single-outstanding memory request FSM and one-entry stall buffer.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o,
    output fetch_state_e    state_o
);

    // Memory handshake: a request is accepted in a cycle where imem_req and imem_gnt are
    // both high; its single response arrives later as one cycle of imem_rvalid with imem_rdata.

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic            load;
    logic [XLEN-1:0] load_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= word_align(RESET_PC);
            req_pc_q <= '0;
            buf_q    <= NOP_INSTR;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            buf_q    <= buf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        buf_d      = buf_q;
        imem_req   = 1'b0;
        load       = 1'b0;
        load_instr = imem_rdata;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (!PCSrc) begin
                    imem_req = 1'b1;
                    if (imem_gnt) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                    if (!PCSrc) begin
                        if (stall) begin
                            buf_d   = imem_rdata;
                            state_d = S_HOLD;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end else if (PCSrc) begin
                    // The response is still in flight; wait for it and throw it away.
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_d = S_FETCH;
            end
            S_HOLD: begin
                if (PCSrc || !stall) state_d = S_FETCH;
                if (!PCSrc && !stall) begin
                    load       = 1'b1;
                    load_instr = buf_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect retargets pc whatever the state, overriding the sequential increment.
        if (PCSrc) pc_d = word_align(PCTarget);
    end

    assign imem_addr = pc_q;
    assign state_o   = state_q;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (PCSrc),
        .hold_i     (stall),
        .load_i     (load),
        .instr_i    (load_instr),
        .pc_i       (req_pc_q),
        .instr_o    (instr_o),
        .pc_o       (pc_o),
        .pc_plus4_o (pc_plus4_o),
        .valid_o    (valid_o)
    );

endmodule
